// File: rtl/cdb_arbiter_pkg.sv
// Shared types and constants for the common data bus arbiter and its consumers.
package cdb_arbiter_pkg;

  typedef logic [3:0]  rob_id_t;
  typedef logic [31:0] data_t;

  localparam logic    TRUE      = 1'b1;
  localparam logic    FALSE     = 1'b0;
  localparam rob_id_t ZERO_ROB  = '0;
  localparam data_t   ZERO_WORD = '0;

  localparam logic CDB_SRC_ALU = 1'b0;
  localparam logic CDB_SRC_LSU = 1'b1;

  // Occupancy counter width: must represent 0..depth inclusive.
  function automatic int unsigned cnt_width(int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/cdb_fifo.sv
// Per-source result FIFO: registered storage, combinational head, synchronous flush.
module cdb_fifo
  import cdb_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 36,
  localparam int unsigned PtrW = $clog2(DEPTH),
  localparam int unsigned CntW = cnt_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic [CntW-1:0]  count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full    = (cnt_q == CntW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign dout    = mem_q[rd_ptr_q];
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of two.
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: the count gates every read that matters.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter driving a single registered CDB from the ALU and LSU result FIFOs.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned ROB_ID_W = 4,
  parameter int unsigned DATA_W   = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                flush,
  input  logic                alu_valid,
  input  logic [ROB_ID_W-1:0] alu_rob_id,
  input  logic [DATA_W-1:0]   alu_result,
  output logic                alu_ready,
  input  logic                lsu_valid,
  input  logic [ROB_ID_W-1:0] lsu_rob_id,
  input  logic [DATA_W-1:0]   lsu_result,
  output logic                lsu_ready,
  output logic                cdb_valid,
  output logic [ROB_ID_W-1:0] cdb_rob_id,
  output logic [DATA_W-1:0]   cdb_result,
  output logic                cdb_src
);

  localparam int unsigned CntW   = cnt_width(DEPTH);
  localparam int unsigned EntryW = ROB_ID_W + DATA_W;

  logic [EntryW-1:0] alu_dout, lsu_dout;
  logic              alu_empty, lsu_empty;
  logic              alu_full, lsu_full;
  logic [CntW-1:0]   alu_count, lsu_count;
  logic              alu_push, lsu_push;
  logic              alu_pop, lsu_pop;

  logic                rr_q, rr_d;
  logic                valid_q, valid_d;
  logic [ROB_ID_W-1:0] rob_q, rob_d;
  logic [DATA_W-1:0]   res_q, res_d;
  logic                src_q, src_d;

  // Readiness deliberately ignores a same-cycle pop so ready never depends on the arbiter.
  assign alu_ready = rdy && !flush && (alu_count < CntW'(DEPTH));
  assign lsu_ready = rdy && !flush && (lsu_count < CntW'(DEPTH));
  assign alu_push  = alu_valid && alu_ready;
  assign lsu_push  = lsu_valid && lsu_ready;

  cdb_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EntryW)
  ) u_alu_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (alu_push),
    .pop   (alu_pop),
    .din   ({alu_rob_id, alu_result}),
    .dout  (alu_dout),
    .empty (alu_empty),
    .full  (alu_full),
    .count (alu_count)
  );

  cdb_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EntryW)
  ) u_lsu_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (lsu_push),
    .pop   (lsu_pop),
    .din   ({lsu_rob_id, lsu_result}),
    .dout  (lsu_dout),
    .empty (lsu_empty),
    .full  (lsu_full),
    .count (lsu_count)
  );

  // Pop selection; the pointer only moves when both sources actually competed.
  always_comb begin
    alu_pop = FALSE;
    lsu_pop = FALSE;
    rr_d    = rr_q;
    if (flush) begin
      rr_d = CDB_SRC_ALU;
    end else if (rdy) begin
      if (!alu_empty && !lsu_empty) begin
        if (rr_q == CDB_SRC_ALU) alu_pop = TRUE;
        else                     lsu_pop = TRUE;
        rr_d = ~rr_q;
      end else if (!alu_empty) begin
        alu_pop = TRUE;
      end else if (!lsu_empty) begin
        lsu_pop = TRUE;
      end
    end
  end

  always_comb begin
    valid_d = valid_q;
    rob_d   = rob_q;
    res_d   = res_q;
    src_d   = src_q;
    if (flush) begin
      valid_d = FALSE;
    end else if (rdy) begin
      valid_d = alu_pop || lsu_pop;
      if (alu_pop) begin
        {rob_d, res_d} = alu_dout;
        src_d          = CDB_SRC_ALU;
      end else if (lsu_pop) begin
        {rob_d, res_d} = lsu_dout;
        src_d          = CDB_SRC_LSU;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_q    <= CDB_SRC_ALU;
      valid_q <= FALSE;
      rob_q   <= '0;
      res_q   <= '0;
      src_q   <= CDB_SRC_ALU;
    end else begin
      rr_q    <= rr_d;
      valid_q <= valid_d;
      rob_q   <= rob_d;
      res_q   <= res_d;
      src_q   <= src_d;
    end
  end

  assign cdb_valid  = valid_q;
  assign cdb_rob_id = rob_q;
  assign cdb_result = res_q;
  assign cdb_src    = src_q;

  a_one_pop: assert property (@(posedge clk) disable iff (!rst) !(alu_pop && lsu_pop));
  a_alu_full: assert property (@(posedge clk) disable iff (!rst)
                               alu_full == (alu_count == CntW'(DEPTH)));
  a_lsu_full: assert property (@(posedge clk) disable iff (!rst)
                               lsu_full == (lsu_count == CntW'(DEPTH)));

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Shares one registered common data bus (CDB) between two result producers: the arithmetic unit and the load/store unit.
- Each producer pushes into its own small result FIFO. A round-robin scheduler pops one entry per cycle and broadcasts it to the ROB, the RS, the LSB and the dispatcher forwarding path.
- Sits between the execution units and all CDB consumers. Handles rollback flush and the global rdy stall.

Parameters:
- DEPTH, 4, entries per source FIFO; must be a power of 2, at least 2.
- ROB_ID_W, 4, ROB id width; must match ROB_ID_TYPE.
- DATA_W, 32, result width; must match DATA_TYPE.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- rdy  in  1  global ready; low freezes the block.
- flush  in  1  rollback from the ROB; synchronous clear.
- alu_valid  in  1  arithmetic result offered.
- alu_rob_id  in  ROB_ID_W  tag of the arithmetic result.
- alu_result  in  DATA_W  arithmetic result value.
- alu_ready  out  1  arithmetic FIFO can accept.
- lsu_valid  in  1  load/store result offered.
- lsu_rob_id  in  ROB_ID_W  tag of the load/store result.
- lsu_result  in  DATA_W  load/store result value.
- lsu_ready  out  1  load/store FIFO can accept.
- cdb_valid  out  1  broadcast valid, one-cycle pulse per entry.
- cdb_rob_id  out  ROB_ID_W  broadcast tag.
- cdb_result  out  DATA_W  broadcast value.
- cdb_src  out  1  source of the current broadcast: 0 = ALU, 1 = LSU.

Behaviour:
- Reset (rst low, asynchronous assert): both FIFOs empty; cdb_valid = 0, cdb_rob_id = 0, cdb_result = 0, cdb_src = 0; round-robin pointer = ALU.
- Ready outputs are combinational:
  - alu_ready = rdy && !flush && (alu_count < DEPTH); lsu_ready likewise.
  - No same-cycle pop credit: a full FIFO stays not-ready even in a cycle where it is popped.
- Push: at the rising edge where x_valid && x_ready, the entry is written at the write pointer.
  - Pointers wrap mod DEPTH.
  - Count is log2(DEPTH)+1 bits wide.
  - x_valid while x_ready = 0: the offer is not taken; the producer must hold it.
- Pop and schedule, evaluated each edge with rdy = 1 and flush = 0:
  - Neither FIFO non-empty: cdb_valid <= 0; cdb_rob_id, cdb_result and cdb_src hold their last values.
  - Exactly one FIFO non-empty: pop it.
  - Both non-empty: pop the FIFO named by the pointer, then flip the pointer.
  - Pointer changes only when both FIFOs competed.
  - On any pop: cdb_valid <= 1 and the popped tag, value and source are registered.
- Latency: a result accepted at edge k is broadcast in the cycle after edge k+1 at the earliest. There is no empty-FIFO bypass.
- Simultaneous push and pop on the same FIFO: count unchanged; both pointers advance.
- rdy low: no push (ready outputs are low), no pop; all registers, including the cdb_* outputs, hold.
- flush high, at the next edge, regardless of rdy:
  - both FIFOs cleared;
  - cdb_valid <= 0;
  - pointer <= ALU;
  - same-cycle offers dropped (ready is already low).
  - flush outranks any pop.
- Reset asserted mid-operation: immediate clear to reset values. Entries in flight are lost by design, because the ROB also resets.
- The block does not reorder entries within one source: per-source FIFO order is preserved.
- One pop per cycle maximum.
- Tag 0 is not special and is carried like any other tag.

Decomposition:
- Shared constants file: ROB_ID_TYPE, DATA_TYPE, TRUE, FALSE, ZERO_ROB, ZERO_WORD; new defines CDB_SRC_ALU = 1'b0 and CDB_SRC_LSU = 1'b1.
- One sub-module, cdb_fifo:
  - parameterised DEPTH and entry width;
  - ports push, pop, din, dout (head, combinational), empty, full, count, flush, same clk and rst;
  - instantiated twice, storing {rob_id, result}.
- The arbiter top holds the pointer, the pop selection and the output registers.

Test Plan:
- Reset then idle: cdb_valid = 0, all cdb_* = 0, alu_ready = lsu_ready = 1. Assert rst low mid-cycle and check the outputs clear immediately.
- Single ALU result:
  - Offer alu rob_id = 3, result = 0x0000_00AA at edge 1.
  - Expect cdb_valid = 1, cdb_rob_id = 3, cdb_result = 0xAA, cdb_src = 0 after edge 2, for exactly one cycle.
- Contention:
  - Preload ALU tags 1, 2 and LSU tags 9, 10; pointer = ALU.
  - Expected broadcast order: 1, 9, 2, 10.
- Full backpressure:
  - Hold lsu_valid with cdb blocked via rdy = 0 after 4 pushes; lsu_ready = 0.
  - Release rdy: entries drain in order, and lsu_ready returns to 1 only after the count drops below 4.
- Flush: with 3 ALU and 2 LSU entries pending plus a new offer, pulse flush. Expect the next cycle cdb_valid = 0, both FIFOs empty, the offer dropped, and the pointer reset to ALU.
- rdy stall: broadcast tag 5, drop rdy for 3 cycles. cdb_valid, cdb_rob_id = 5 and cdb_src hold; no push or pop occurs.
